// File: rtl/sse_pkg.sv
// Shared types for the SSE operand-stream driver: FSM states, fp32 words,
// and the operand-pair record held in the buffer.
package sse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } pair_t;

    localparam fp32_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/sse_pair_buf.sv
// DEPTH x 64-bit operand-pair register file: one synchronous write port,
// one asynchronous read port. Out-of-range writes are dropped, reads return zero.
module sse_pair_buf
    import sse_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pair_t         wdata,
    input  logic [AW-1:0] raddr,
    output pair_t         rdata
);

    pair_t mem [DEPTH];
    logic  wr_ok;

    // When DEPTH fills the address space every address is valid, so no compare is built.
    generate
        if (DEPTH == (2 ** AW)) begin : g_full
            assign wr_ok = 1'b1;
            assign rdata = mem[raddr];
        end else begin : g_part
            assign wr_ok = (waddr < AW'(DEPTH));
            assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/sse_stream_driver.sv
// Producer end of the SSE operand stream: replays buffered operand pairs one per
// consumer request, flags end-of-stream, then captures the consumer's result.
module sse_stream_driver
    import sse_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_a,
    input  logic [31:0]   load_b,
    input  logic [AW:0]   count,
    input  logic          go,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [31:0]   result,
    output logic [31:0]   A,
    output logic [31:0]   B,
    output logic          stop,
    input  logic          sse_next,
    input  logic          sse_ready,
    input  logic [31:0]   sse_y
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW:0]   cnt, cnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          next_q;
    logic          adv;
    logic          last;
    logic [AW-1:0] rd_addr;
    pair_t         rd_pair;
    fp32_t         a_n, b_n, result_n;
    logic          stop_n, busy_n, done_n, timeout_n;

    sse_pair_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (load_we && (state == IDLE)),
        .waddr (load_addr),
        .wdata ({load_a, load_b}),
        .raddr (rd_addr),
        .rdata (rd_pair)
    );

    // A level-high sse_next produces a single advance on its rising edge.
    assign adv     = sse_next & ~next_q;
    assign last    = ({1'b0, idx} == (cnt - (AW+1)'(1)));
    assign rd_addr = (state == STREAM) ? (idx + AW'(1)) : '0;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        wcnt_n    = wcnt;
        a_n       = A;
        b_n       = B;
        stop_n    = stop;
        busy_n    = busy;
        done_n    = 1'b0;
        result_n  = result;
        timeout_n = timeout;
        case (state)
            IDLE: begin
                if (go) begin
                    timeout_n = 1'b0;
                    if (count == '0) begin
                        done_n   = 1'b1;
                        result_n = FP_ZERO;
                    end else begin
                        cnt_n   = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
                        idx_n   = '0;
                        a_n     = rd_pair.a;
                        b_n     = rd_pair.b;
                        busy_n  = 1'b1;
                        state_n = STREAM;
                    end
                end
            end
            STREAM: begin
                if (adv) begin
                    if (last) begin
                        // Zero operands keep the consumer's sum unchanged while it drains.
                        a_n     = FP_ZERO;
                        b_n     = FP_ZERO;
                        stop_n  = 1'b1;
                        wcnt_n  = '0;
                        state_n = DRAIN;
                    end else begin
                        idx_n = idx + AW'(1);
                        a_n   = rd_pair.a;
                        b_n   = rd_pair.b;
                    end
                end
            end
            DRAIN: begin
                if (sse_ready) begin
                    result_n = sse_y;
                    done_n   = 1'b1;
                    stop_n   = 1'b0;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end else if (wcnt == WW'(TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    stop_n    = 1'b0;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            wcnt    <= '0;
            next_q  <= 1'b0;
            A       <= FP_ZERO;
            B       <= FP_ZERO;
            stop    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= FP_ZERO;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            wcnt    <= wcnt_n;
            next_q  <= sse_next;
            A       <= a_n;
            B       <= b_n;
            stop    <= stop_n;
            busy    <= busy_n;
            done    <= done_n;
            result  <= result_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: doc/sse_stream_driver.md
Name: sse_stream_driver

Overview:
- Producer end of the SSE operand-stream interface: buffers up to DEPTH floating-point operand pairs, feeds them to the SSE consumer one pair per `next` request, raises `stop` after the last pair, then captures the consumer's result when its `ready` asserts.
- Sits between the host/testbench load path and the SSE accumulator.
- Moves data only; no arithmetic on operand values.

Parameters:
- DEPTH, 16, operand-pair buffer entries.
- AW, 4, buffer address/count width; DEPTH <= 2**AW.
- TIMEOUT, 1024, max cycles in DRAIN waiting for sse_ready before abort.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_we  in  1  write one pair into the buffer.
- load_addr  in  AW  buffer write address.
- load_a  in  32  IEEE-754 single, A operand.
- load_b  in  32  IEEE-754 single, B operand.
- count  in  AW+1  number of pairs to stream; sampled on go.
- go  in  1  start a run; honoured only in IDLE.
- busy  out  1  high in STREAM and DRAIN.
- done  out  1  one-cycle pulse when result is valid.
- timeout  out  1  sticky; set on DRAIN expiry, cleared by next accepted go or by rst.
- result  out  32  captured sum of squared error; held until next done.
- A  out  32  operand to consumer.
- B  out  32  operand to consumer.
- stop  out  1  end-of-stream flag to consumer.
- sse_next  in  1  consumer request or acknowledge; level signal, only rising edges count.
- sse_ready  in  1  consumer result valid.
- sse_y  in  32  consumer result.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE; A=B=0; stop=0; busy=0; done=0; timeout=0; result=0; idx=0; next_q=0.
  - Buffer contents are not reset and are unspecified after reset.
- Edge detect: next_q registers sse_next. An advance event is sse_next & ~next_q. A held-high sse_next yields exactly one event.
- Buffer write: load_we in IDLE writes {load_a, load_b} at load_addr. load_we while busy is ignored. load_addr >= DEPTH is ignored.
- IDLE:
  - go with count==0: next cycle done=1, result=0, timeout cleared; stay IDLE.
  - go with 1 <= count <= DEPTH: latch count, idx=0, clear timeout. Next cycle A/B = pair 0, busy=1, state=STREAM.
  - go with count > DEPTH: treated as count=DEPTH.
- STREAM:
  - Advance event with idx < cnt-1: idx++; the following cycle A/B = pair idx.
  - Advance event with idx == cnt-1: the following cycle A=B=0 (zero pairs contribute 0 to the sum), stop=1, state=DRAIN, wait counter=0.
  - go is ignored throughout.
- DRAIN:
  - stop held 1 and A=B=0; further advance events are ignored.
  - sse_ready sampled 1: result<=sse_y, done=1 for one cycle, stop=0, busy=0, state=IDLE.
  - Wait counter reaches TIMEOUT-1 with no sse_ready: timeout=1, stop=0, busy=0, result unchanged, no done pulse, state=IDLE.
- Simultaneous sse_ready and advance event in DRAIN: capture wins.
- sse_ready seen in STREAM is ignored; only DRAIN captures.
- Latency:
  - go to first pair valid on A/B: 1 cycle.
  - Advance event to next pair: 1 cycle after the edge is registered.
  - sse_ready to done: 1 cycle.
- Outputs A, B, stop, busy, done, result, timeout are all registered.

Decomposition:
- Package sse_pkg: state enum (IDLE, STREAM, DRAIN), fp32 typedef (logic [31:0]), operand-pair struct {a, b}, FP_ZERO constant.
- One sub-module: sse_pair_buf, a DEPTH x 64 register file with one write port and one async read port. All control stays in the top.

Test Plan:
- Load pairs (0x40400000, 0x3F800000), (0x40A00000, 0x40000000), (0x3F800000, 0x3F800000); count=3; go. Consumer model pulses sse_next every 8 cycles -> A/B show pair0, pair1, pair2 in order, then 0/0 with stop=1 one cycle after the third edge; busy high throughout.
- Continue run: sse_ready=1, sse_y=0x41500000 -> result=0x41500000, done high exactly 1 cycle, stop and busy low the next cycle.
- count=0, go -> done one cycle later, result=0, stop never asserted, A/B stay 0.
- In STREAM, hold sse_next high 20 cycles, then drop and re-raise -> exactly two advances; load_we during run leaves buffer unchanged (verified on a later run).
- TIMEOUT=64, sse_ready never asserted -> timeout=1 at the 64th DRAIN cycle, no done, IDLE; the next go clears timeout.
- Assert rst mid-STREAM between clock edges -> A/B/stop/busy go to 0 immediately; a subsequent go restarts from pair 0.
